freq_gate_ctrl: RTL and testbench

Gate-timing controller for the 6-digit BCD frequency counter. It sequences each measurement: clear the counter, open a precise gate window of GATE_CYCLES system clocks, let the count settle, latch the 24-bit BCD result into a display register. It sits between the system clock domain and the F_IN-clocked counter, which it drives through that counter's ENA and CLR inputs. It supports single-shot and continuous measurement.

---
 rtl/freq_gate_ctrl.sv | 140 ++++++++++++++
 tb/tb_freq_gate_ctrl.sv | 326 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/freq_gate_ctrl.sv
// freq_gate_ctrl
// Gate-timing sequencer for the 6-digit BCD frequency counter. One measurement
// clears the F_IN counter, opens the gate for exactly GATE_CYCLES clocks, waits
// SETTLE_CYCLES for the counter to freeze, then latches Q into DISP.
//
// Ports
//   CLK    system clock, all state on the rising edge
//   RST_N  asynchronous active-low reset
//   START  level, sampled only in IDLE, starts a measurement
//   CONT   continuous mode, sampled in LATCH
//   ABORT  level, returns any active measurement to IDLE (highest priority)
//   Q      24-bit BCD count from the F_IN counter
//   ENA    counter enable (gate open)
//   CLR    counter clear, active high
//   DISP   latched result of the last completed measurement
//   DONE   one-cycle pulse while DISP holds a fresh result
//   BUSY   high whenever a measurement is in progress
//
// state  | meaning
// IDLE   | waiting for START, counter held in clear
// CLEAR  | counter clear pulse, CLR_CYCLES long
// GATE   | gate open, GATE_CYCLES long
// SETTLE | gate closed, counter output settling, SETTLE_CYCLES long
// LATCH  | single cycle, DISP freshly loaded, DONE high
module freq_gate_ctrl #(
    parameter int unsigned GATE_CYCLES   = 50_000_000,
    parameter int unsigned CLR_CYCLES    = 4,
    parameter int unsigned SETTLE_CYCLES = 8
) (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic        START,
    input  logic        CONT,
    input  logic        ABORT,
    input  logic [23:0] Q,
    output logic        ENA,
    output logic        CLR,
    output logic [23:0] DISP,
    output logic        DONE,
    output logic        BUSY
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_CLEAR  = 3'd1;
    localparam logic [2:0] S_GATE   = 3'd2;
    localparam logic [2:0] S_SETTLE = 3'd3;
    localparam logic [2:0] S_LATCH  = 3'd4;

    // The timer is loaded with length-1 on entry and the state is left on the
    // edge after it reaches zero, so each state lasts exactly its length.
    localparam logic [31:0] CLR_LOAD    = 32'(CLR_CYCLES - 1);
    localparam logic [31:0] GATE_LOAD   = 32'(GATE_CYCLES - 1);
    localparam logic [31:0] SETTLE_LOAD = 32'(SETTLE_CYCLES - 1);

    logic [2:0]  state_q, state_d;
    logic [31:0] timer_q, timer_d;
    logic [23:0] disp_q, disp_d;

    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        disp_d  = disp_q;

        if (timer_q != 32'd0) begin
            timer_d = timer_q - 32'd1;
        end

        case (state_q)
            S_IDLE: begin
                timer_d = 32'd0;
                if (START && !ABORT) begin
                    state_d = S_CLEAR;
                    timer_d = CLR_LOAD;
                end
            end
            S_CLEAR: begin
                if (timer_q == 32'd0) begin
                    state_d = S_GATE;
                    timer_d = GATE_LOAD;
                end
            end
            S_GATE: begin
                if (timer_q == 32'd0) begin
                    state_d = S_SETTLE;
                    timer_d = SETTLE_LOAD;
                end
            end
            S_SETTLE: begin
                // Counter has been frozen for SETTLE_CYCLES, so the unsynchronized
                // Q bus is stable and safe to sample here.
                if (timer_q == 32'd0) begin
                    state_d = S_LATCH;
                    timer_d = 32'd0;
                    disp_d  = Q;
                end
            end
            S_LATCH: begin
                timer_d = 32'd0;
                if (CONT) begin
                    state_d = S_CLEAR;
                    timer_d = CLR_LOAD;
                end else begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
                timer_d = 32'd0;
            end
        endcase

        // Abort wins over every transition, including the latch of a result.
        if (ABORT && (state_q != S_IDLE)) begin
            state_d = S_IDLE;
            timer_d = 32'd0;
            disp_d  = disp_q;
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= S_IDLE;
            timer_q <= 32'd0;
            disp_q  <= 24'h000000;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            disp_q  <= disp_d;
        end
    end

    // Moore decode straight from the state register; no input reaches an output
    // without passing through a flop.
    assign ENA  = (state_q == S_GATE);
    assign CLR  = (state_q == S_IDLE) || (state_q == S_CLEAR);
    assign DONE = (state_q == S_LATCH);
    assign BUSY = (state_q != S_IDLE);
    assign DISP = disp_q;

endmodule

// File: tb/tb_freq_gate_ctrl.sv
// Bench for freq_gate_ctrl: directed single-shot, continuous, abort, wrap and
// reset scenarios against a bench-side F_IN counter, then randomized control
// inputs and Q against a timeline model of the measurement sequence.
module tb_freq_gate_ctrl;

    localparam int G = 100;
    localparam int C = 2;
    localparam int S = 4;
    localparam int N = C + G + S;

    logic        CLK   = 1'b0;
    logic        RST_N = 1'b0;
    logic        START = 1'b0;
    logic        CONT  = 1'b0;
    logic        ABORT = 1'b0;
    logic [23:0] Q;
    logic        ENA, CLR, DONE, BUSY;
    logic [23:0] DISP;

    int n_checks = 0;
    int n_errors = 0;
    bit chk_en   = 1'b0;
    int cyc      = 0;

    freq_gate_ctrl #(
        .GATE_CYCLES  (G),
        .CLR_CYCLES   (C),
        .SETTLE_CYCLES(S)
    ) dut (
        .CLK  (CLK),
        .RST_N(RST_N),
        .START(START),
        .CONT (CONT),
        .ABORT(ABORT),
        .Q    (Q),
        .ENA  (ENA),
        .CLR  (CLR),
        .DISP (DISP),
        .DONE (DONE),
        .BUSY (BUSY)
    );

    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc <= cyc + 1;

    // F_IN source; rising edges always fall 2 time units after a CLK rising edge
    // and never coincide with either CLK edge.
    logic f_in     = 1'b0;
    int   fin_half = 20;
    initial begin
        #17;
        f_in = 1'b1;
        forever begin
            #(fin_half);
            f_in = ~f_in;
        end
    end

    // F_IN counter: async clear, counts step per F_IN edge while ENA, wraps at 10^6.
    int cnt  = 0;
    int step = 1;
    always @(posedge f_in or posedge CLR) begin
        if (CLR) cnt <= 0;
        else if (ENA) cnt <= (cnt + step) % 1000000;
    end

    function automatic logic [23:0] to_bcd(input int v);
        logic [23:0] r;
        int x;
        x = v;
        r = '0;
        for (int i = 0; i < 6; i++) begin
            r[i*4 +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    bit          q_rand_mode = 1'b0;
    logic [23:0] q_rand      = '0;
    assign Q = q_rand_mode ? q_rand : to_bcd(cnt);

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h want 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic timeout(input string name);
        n_checks++;
        n_errors++;
        $display("FAIL %s: timed out waiting (t=%0t)", name, $time);
    endtask

    // Timeline model: a measurement is "active" with k = clock edges since the
    // edge that accepted START. k in [0,C) clear, [C,C+G) gate, [C+G,N) settle,
    // k == N latch.
    bit          m_active = 1'b0;
    int          m_k      = 0;
    logic [23:0] m_disp   = '0;

    initial begin
        forever begin
            @(posedge CLK or negedge RST_N);
            if (!RST_N) begin
                m_active = 1'b0;
                m_k      = 0;
                m_disp   = '0;
            end else if (!m_active) begin
                if (START && !ABORT) begin
                    m_active = 1'b1;
                    m_k      = 0;
                end
            end else if (ABORT) begin
                m_active = 1'b0;
            end else if (m_k == N) begin
                if (CONT) m_k = 0;
                else m_active = 1'b0;
            end else begin
                m_k = m_k + 1;
                if (m_k == N) m_disp = Q;
            end
        end
    end

    initial begin
        logic e_ena, e_clr, e_busy, e_done;
        forever begin
            @(negedge CLK);
            if (chk_en) begin
                e_ena  = m_active && (m_k >= C) && (m_k < C + G);
                e_clr  = !m_active || (m_k < C);
                e_busy = m_active;
                e_done = m_active && (m_k == N);
                check("model_ena",  32'(ENA),  32'(e_ena));
                check("model_clr",  32'(CLR),  32'(e_clr));
                check("model_busy", 32'(BUSY), 32'(e_busy));
                check("model_done", 32'(DONE), 32'(e_done));
                check("model_disp", 32'(DISP), 32'(m_disp));
            end
        end
    end

    task automatic pulse_start(output int e0);
        @(negedge CLK);
        START = 1'b1;
        @(negedge CLK);
        START = 1'b0;
        e0 = cyc;
        check("start_busy", 32'(BUSY), 32'd1);
        check("start_clr",  32'(CLR),  32'd1);
    endtask

    task automatic wait_done(input int e0, output int rel, output int ena_cnt, output bit ok);
        ok      = 1'b0;
        rel     = -1;
        ena_cnt = 0;
        for (int i = 0; i < 400; i++) begin
            @(negedge CLK);
            if (ENA) ena_cnt++;
            if (DONE) begin
                rel = cyc - e0;
                ok  = 1'b1;
                break;
            end
        end
        if (!ok) timeout("wait_done");
    endtask

    task automatic reset_pulse(input int hold);
        #3;
        RST_N = 1'b0;
        #1;
        check("rst_ena",  32'(ENA),  32'd0);
        check("rst_clr",  32'(CLR),  32'd1);
        check("rst_disp", 32'(DISP), 32'd0);
        check("rst_done", 32'(DONE), 32'd0);
        check("rst_busy", 32'(BUSY), 32'd0);
        repeat (hold) @(negedge CLK);
        RST_N = 1'b1;
    endtask

    task automatic single_shot(input logic [23:0] want_disp);
        int e0, rel, ena_cnt;
        bit ok;
        pulse_start(e0);
        wait_done(e0, rel, ena_cnt, ok);
        if (ok) begin
            check("ss_done_edge", 32'(rel), 32'd106);
            check("ss_ena_cycles", 32'(ena_cnt), 32'd100);
            check("ss_disp", 32'(DISP), 32'(want_disp));
            @(negedge CLK);
            check("ss_busy_after", 32'(BUSY), 32'd0);
            check("ss_done_after", 32'(DONE), 32'd0);
        end
    endtask

    initial begin
        int e0, rel, rel_prev, ena_cnt, clr_n, done_n;
        bit ok, seen;

        repeat (3) @(negedge CLK);
        check("init_ena",  32'(ENA),  32'd0);
        check("init_clr",  32'(CLR),  32'd1);
        check("init_disp", 32'(DISP), 32'd0);
        check("init_done", 32'(DONE), 32'd0);
        check("init_busy", 32'(BUSY), 32'd0);
        RST_N  = 1'b1;
        chk_en = 1'b1;
        repeat (3) @(negedge CLK);

        // Single shot: 25 F_IN edges in a 1000-unit gate.
        single_shot(24'h000025);

        // Continuous mode.
        CONT = 1'b1;
        pulse_start(e0);
        wait_done(e0, rel_prev, ena_cnt, ok);
        for (int p = 0; p < 2 && ok; p++) begin
            clr_n = 0;
            seen  = 1'b0;
            for (int i = 0; i < 20; i++) begin
                @(negedge CLK);
                if (ENA) begin
                    seen = 1'b1;
                    break;
                end
                if (CLR) clr_n++;
            end
            if (!seen) timeout("cont_gate");
            check("cont_clr_between", 32'(clr_n), 32'd2);
            wait_done(e0, rel, ena_cnt, ok);
            if (ok) begin
                check("cont_period", 32'(rel - rel_prev), 32'd107);
                check("cont_disp", 32'(DISP), 32'h25);
            end
            rel_prev = rel;
        end
        CONT = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(negedge CLK);
            if (!BUSY) begin
                seen = 1'b1;
                break;
            end
        end
        if (!seen) timeout("cont_stop");

        // Abort at gate cycle 50.
        pulse_start(e0);
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge CLK);
            if (ENA) begin
                seen = 1'b1;
                break;
            end
        end
        if (!seen) timeout("abort_gate");
        repeat (49) @(negedge CLK);
        ABORT = 1'b1;
        @(negedge CLK);
        ABORT = 1'b0;
        check("abort_ena",  32'(ENA),  32'd0);
        check("abort_clr",  32'(CLR),  32'd1);
        check("abort_busy", 32'(BUSY), 32'd0);
        check("abort_disp", 32'(DISP), 32'h25);
        done_n = 0;
        for (int i = 0; i < 150; i++) begin
            @(negedge CLK);
            if (DONE) done_n++;
        end
        check("abort_no_done", 32'(done_n), 32'd0);
        START = 1'b1;
        ABORT = 1'b1;
        repeat (3) @(negedge CLK);
        check("start_abort_idle", 32'(BUSY), 32'd0);
        START = 1'b0;
        ABORT = 1'b0;
        repeat (2) @(negedge CLK);

        // Wrap: 5 edges x 200001 = 1000005 counts.
        step     = 200001;
        fin_half = 100;
        repeat (40) @(negedge CLK);
        single_shot(24'h000005);
        step     = 1;
        fin_half = 20;
        repeat (40) @(negedge CLK);

        // Reset during SETTLE, then a full-length measurement.
        pulse_start(e0);
        seen = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge CLK);
            if (ENA) seen = 1'b1;
            else if (seen) break;
        end
        if (!seen) timeout("settle_reach");
        reset_pulse(3);
        repeat (2) @(negedge CLK);
        single_shot(24'h000025);

        // Randomized control inputs and Q.
        q_rand_mode = 1'b1;
        for (int i = 0; i < 4000; i++) begin
            @(negedge CLK);
            START = ($urandom_range(3) == 0);
            CONT  = 1'($urandom_range(1));
            ABORT = ($urandom_range(199) == 0);
            for (int d = 0; d < 6; d++) q_rand[d*4 +: 4] = 4'($urandom_range(9));
            if ($urandom_range(999) == 0) reset_pulse(2);
        end
        START = 1'b0;
        CONT  = 1'b0;
        ABORT = 1'b0;
        repeat (3) @(negedge CLK);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
